// File: rtl/tdm_demux4_5_if.sv
// tdm_demux4_5_if: link word input and committed lane outputs of the 1-to-4 TDM demultiplexer
interface tdm_demux4_5_if #(parameter int W = 5);
  logic [W-1:0] din;
  logic valid;
  logic frame;
  logic [W-1:0] O0, O1, O2, O3;
  logic upd;
  logic err;
  logic locked;
  logic [1:0] slot;
  modport master (output din, valid, frame, input O0, O1, O2, O3, upd, err, locked, slot);
  modport slave (input din, valid, frame, output O0, O1, O2, O3, upd, err, locked, slot);
endinterface

// File: rtl/tdm_demux4_5.sv
// tdm_demux4_5: rebuilds four W-bit lanes from a framed word stream and commits them together
module tdm_demux4_5 #(parameter int W = 5) (
  input logic clk,
  input logic rst,
  tdm_demux4_5_if.slave bus
);
  typedef enum logic {HUNT, RUN} state_t;
  state_t state, state_n;
  logic [1:0] slot, slot_n;
  logic [W-1:0] s0, s1, s2;
  logic ld0, ld1, ld2, commit, err_n;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= HUNT;
    else state <= state_n;
  // next state and slot-word decode; early marker restarts the frame, missing marker drops lock
  always_comb begin
    state_n = state;
    slot_n = slot;
    ld0 = 1'b0;
    ld1 = 1'b0;
    ld2 = 1'b0;
    commit = 1'b0;
    err_n = 1'b0;
    if (bus.valid) begin
      if (state == HUNT) begin
        if (bus.frame) begin
          ld0 = 1'b1;
          slot_n = 2'd1;
          state_n = RUN;
        end
      end else if (bus.frame) begin
        ld0 = 1'b1;
        slot_n = 2'd1;
        err_n = slot != 2'd0;
      end else if (slot == 2'd0) begin
        err_n = 1'b1;
        state_n = HUNT;
      end else begin
        slot_n = slot + 2'd1;
        ld1 = slot == 2'd1;
        ld2 = slot == 2'd2;
        commit = slot == 2'd3;
      end
    end
  end
  // slot counter, shadow buffer, committed lanes and status pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      slot <= '0;
      {s0, s1, s2} <= '0;
      {bus.O0, bus.O1, bus.O2, bus.O3} <= '0;
      bus.upd <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      slot <= slot_n;
      if (ld0) s0 <= bus.din;
      if (ld1) s1 <= bus.din;
      if (ld2) s2 <= bus.din;
      if (commit) {bus.O0, bus.O1, bus.O2, bus.O3} <= {s0, s1, s2, bus.din};
      bus.upd <= commit;
      bus.err <= err_n;
    end
  assign bus.locked = state == RUN;
  assign bus.slot = slot;
endmodule

// File: tb/tb_tdm_demux4_5.sv
// tb_tdm_demux4_5: directed checks of framing, commit, error and reset behaviour
module tb_tdm_demux4_5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  tdm_demux4_5_if #(.W(5)) bus ();
  tdm_demux4_5 #(.W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic word(input logic v, input logic f, input logic [4:0] d);
    bus.valid = v;
    bus.frame = f;
    bus.din = d;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [19:0] lanes();
    return {bus.O0, bus.O1, bus.O2, bus.O3};
  endfunction
  function automatic logic [19:0] pk(input logic [4:0] a, b, c, d);
    return {a, b, c, d};
  endfunction
  initial begin
    bus.valid = 1'b0;
    bus.frame = 1'b0;
    bus.din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lanes", lanes(), 20'd0);
    chk("rst_locked", 20'(bus.locked), 20'd0);
    chk("rst_slot", 20'(bus.slot), 20'd0);
    chk("rst_upd", 20'(bus.upd), 20'd0);
    chk("rst_err", 20'(bus.err), 20'd0);
    rst = 1'b0;
    word(0, 0, 5'd0);
    word(1, 0, 5'd9);
    chk("hunt_no_frame_locked", 20'(bus.locked), 20'd0);
    chk("hunt_no_frame_err", 20'(bus.err), 20'd0);
    word(1, 1, 5'd0);
    chk("t1_locked", 20'(bus.locked), 20'd1);
    chk("t1_slot", 20'(bus.slot), 20'd1);
    word(1, 0, 5'd1);
    word(1, 0, 5'd2);
    chk("t1_no_upd_early", 20'(bus.upd), 20'd0);
    word(1, 0, 5'd3);
    chk("t1_upd", 20'(bus.upd), 20'd1);
    chk("t1_lanes", lanes(), pk(5'd0, 5'd1, 5'd2, 5'd3));
    chk("t1_err", 20'(bus.err), 20'd0);
    chk("t1_slot_wrap", 20'(bus.slot), 20'd0);
    word(1, 1, 5'h05);
    chk("t2_upd_one_cycle", 20'(bus.upd), 20'd0);
    word(1, 0, 5'h0A);
    word(1, 0, 5'h05);
    word(0, 0, 5'h1F);
    chk("t2_idle_hold", lanes(), pk(5'd0, 5'd1, 5'd2, 5'd3));
    chk("t2_idle_slot", 20'(bus.slot), 20'd3);
    chk("t2_idle_err", 20'(bus.err), 20'd0);
    chk("t2_idle_upd", 20'(bus.upd), 20'd0);
    word(1, 0, 5'h0A);
    chk("t2_upd", 20'(bus.upd), 20'd1);
    chk("t2_lanes", lanes(), pk(5'h05, 5'h0A, 5'h05, 5'h0A));
    word(1, 1, 5'h1F);
    chk("t3_upd_clear", 20'(bus.upd), 20'd0);
    word(1, 0, 5'h1E);
    word(1, 1, 5'h11);
    chk("t3_err", 20'(bus.err), 20'd1);
    chk("t3_err_no_upd", 20'(bus.upd), 20'd0);
    chk("t3_slot", 20'(bus.slot), 20'd1);
    chk("t3_locked", 20'(bus.locked), 20'd1);
    chk("t3_hold", lanes(), pk(5'h05, 5'h0A, 5'h05, 5'h0A));
    word(1, 0, 5'h12);
    chk("t3_err_one_cycle", 20'(bus.err), 20'd0);
    word(1, 0, 5'h13);
    word(1, 0, 5'h14);
    chk("t3_upd", 20'(bus.upd), 20'd1);
    chk("t3_lanes", lanes(), pk(5'h11, 5'h12, 5'h13, 5'h14));
    word(1, 0, 5'h07);
    chk("t4_err", 20'(bus.err), 20'd1);
    chk("t4_unlocked", 20'(bus.locked), 20'd0);
    chk("t4_slot", 20'(bus.slot), 20'd0);
    chk("t4_hold", lanes(), pk(5'h11, 5'h12, 5'h13, 5'h14));
    word(1, 0, 5'h08);
    chk("t4_err_one_cycle", 20'(bus.err), 20'd0);
    word(1, 0, 5'h09);
    word(1, 0, 5'h0A);
    word(1, 0, 5'h0B);
    chk("t4_ignored_upd", 20'(bus.upd), 20'd0);
    chk("t4_ignored_lanes", lanes(), pk(5'h11, 5'h12, 5'h13, 5'h14));
    chk("t4_ignored_locked", 20'(bus.locked), 20'd0);
    word(1, 1, 5'd1);
    word(1, 0, 5'd2);
    chk("t5_pre_slot", 20'(bus.slot), 20'd2);
    rst = 1'b1;
    #1;
    chk("t5_async_lanes", lanes(), 20'd0);
    chk("t5_async_locked", 20'(bus.locked), 20'd0);
    chk("t5_async_slot", 20'(bus.slot), 20'd0);
    word(0, 0, 5'd0);
    rst = 1'b0;
    word(1, 0, 5'd3);
    word(1, 0, 5'd4);
    chk("t5_after_locked", 20'(bus.locked), 20'd0);
    chk("t5_after_upd", 20'(bus.upd), 20'd0);
    chk("t5_after_lanes", lanes(), 20'd0);
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 4; k++) begin
        word(1, k == 0, 5'(4 * f + k + 1));
        chk($sformatf("t6_f%0d_k%0d_upd", f, k), 20'(bus.upd), 20'(k == 3));
        chk($sformatf("t6_f%0d_k%0d_err", f, k), 20'(bus.err), 20'd0);
        if (k == 3)
          chk($sformatf("t6_f%0d_lanes", f), lanes(),
              pk(5'(4 * f + 1), 5'(4 * f + 2), 5'(4 * f + 3), 5'(4 * f + 4)));
      end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
